cube_frame_rx: RTL and testbench
================================

Name: cube_frame_rx

Overview:
Cube-side receiving end of the serial link that streams the 64-byte LED cube image (address 0..63, one byte per address) out of the cube RAM. It deserialises 8N1 UART bytes from the GPIO line and assembles them into 64-byte frames. Frames are held in a double-buffered frame store: the display scanner reads a stable frame while the next one is written. Buffers swap only on a complete, error-free frame.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200)
FRAME_BYTES, 64, bytes per frame (8x8x8 cube, one byte per row)
IDLE_GAP_BITS, 20, bit-times without a start bit that abort a partial frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input, idle high
rd_addr  in  6  display read address (row index 0..63)
rd_data  out  8  byte at rd_addr from the active buffer, 1-cycle latency
frame_valid  out  1  high once at least one full frame has been swapped in
frame_done  out  1  1-cycle pulse on buffer swap
framing_err  out  1  1-cycle pulse when the stop bit is sampled low
frame_abort  out  1  1-cycle pulse when a partial frame is discarded
frame_count  out  16  count of completed frames, wraps at 65535->0

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: rd_data=0, frame_valid=0, all pulses 0, frame_count=0, byte index=0, active buffer select=0, receive FSM=IDLE. Buffer RAM is not cleared.
- While frame_valid=0, rd_data returns 0 regardless of RAM contents.
- rx passes through a 2-flop synchroniser. All decisions use the synchronised value, adding 2 cycles of input latency.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge of the synchronised rx.
  - START: wait CLKS_PER_BIT/2 cycles (integer division). If rx=1 it is a glitch: return to IDLE with no pulse. If rx=0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx=1: byte accepted.
    - rx=0: framing_err pulses, the byte is dropped, and the partial frame is discarded (frame_abort pulses in the same cycle if byte index != 0). Byte index goes to 0. The FSM waits for rx=1 before re-entering IDLE.
- Accepted byte: written to the back buffer at the current byte index in the same cycle as the stop sample; index then increments.
- On the byte at index FRAME_BYTES-1:
  - next cycle: active select toggles, frame_done pulses, frame_count increments, frame_valid is set, index goes to 0.
  - A new start edge in that cycle is still detected; the swap never blocks reception.
- Idle counter:
  - counts only while byte index != 0 and the FSM is in IDLE;
  - clears on any start edge;
  - on reaching IDLE_GAP_BITS*CLKS_PER_BIT: index goes to 0, frame_abort pulses, no swap.
- Read port:
  - rd_data registered from the active buffer; 1-cycle latency.
  - A swap changes the data seen from the next read onward. No torn frame is ever visible.
- Simultaneous events: framing_err and frame_abort may pulse in the same cycle. frame_done never coincides with either.
- Reset mid-byte or mid-frame: partial data is discarded and the active buffer select returns to 0. frame_valid=0 until the next complete frame.
- Counter widths: bit timer uses $clog2(CLKS_PER_BIT) bits; idle counter uses $clog2(IDLE_GAP_BITS*CLKS_PER_BIT+1) bits; byte index 6 bits. No overflow is possible before terminal compare.

Decomposition:
- Shared package cube_link_pkg holds:
  - FRAME_BYTES, CUBE_ADDR_W=6, CUBE_DATA_W=8;
  - the default baud constant, also used by the transmitter side;
  - the rx FSM state enum.
- One sub-module, uart_rx_core: synchroniser, bit FSM and bit timer. Outputs byte_valid pulse, byte_data[7:0], and framing_err.
- Frame assembly, idle timer, double buffer (2x64x8, inferred RAM) and read port live in cube_frame_rx.

Test Plan:
- Full frame: send bytes 0x00..0x3F at CLKS_PER_BIT=16.
  - frame_done pulses exactly once, 1 cycle after the 64th stop sample.
  - frame_count=1, frame_valid=1.
  - Reading rd_addr=k returns k one cycle later, for all 64 addresses.
- Double-buffer isolation: frame A (all 0xAA) complete, then stream frame B (0x55) while reading continuously.
  - All reads return 0xAA until frame B's frame_done, 0x55 afterwards.
- Framing error: corrupt the stop bit of byte 10 (rx=0).
  - framing_err and frame_abort pulse together; no swap.
  - A following clean 64-byte frame swaps with frame_count=1.
- Idle gap: send 30 bytes, hold rx high for IDLE_GAP_BITS bit-times.
  - frame_abort pulses once.
  - The next 64 bytes form a correct frame; byte 0 lands at address 0.
- Glitch: rx low for CLKS_PER_BIT/2-2 cycles.
  - No byte, no pulses, index unchanged.
- Reset mid-frame: assert rst for 1 cycle after 40 bytes of a second frame.
  - All outputs reset; frame_valid=0 and rd_data=0.
  - The next full frame is received correctly with frame_count=1.

Source files
------------

// File: rtl/cube_link_pkg.sv
// Shared constants and types for the cube serial link (transmitter and receiver sides).
package cube_link_pkg;

  localparam int unsigned FRAME_BYTES        = 64;
  localparam int unsigned CUBE_ADDR_W        = 6;
  localparam int unsigned CUBE_DATA_W        = 8;
  localparam int unsigned CUBE_CLKS_PER_BIT  = 434;  // 50 MHz / 115200 baud
  localparam int unsigned CUBE_IDLE_GAP_BITS = 20;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/cube_frame_rx_if.sv
// Serial input, display read port and frame status of the cube-side frame receiver.
interface cube_frame_rx_if;
  import cube_link_pkg::*;

  logic                   rx;
  logic [CUBE_ADDR_W-1:0] rd_addr;
  logic [CUBE_DATA_W-1:0] rd_data;
  logic                   frame_valid;
  logic                   frame_done;
  logic                   framing_err;
  logic                   frame_abort;
  logic [15:0]            frame_count;

  modport master (
    output rx,
    output rd_addr,
    input  rd_data,
    input  frame_valid,
    input  frame_done,
    input  framing_err,
    input  frame_abort,
    input  frame_count
  );

  modport slave (
    input  rx,
    input  rd_addr,
    output rd_data,
    output frame_valid,
    output frame_done,
    output framing_err,
    output frame_abort,
    output frame_count
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, bit timer and start/data/stop FSM.
module uart_rx_core
  import cube_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CUBE_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err,
  output logic       rx_idle
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            brk_q, brk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RxIdle;
      timer_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      brk_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      brk_q     <= brk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    brk_d       = brk_q;
    byte_valid  = 1'b0;
    framing_err = 1'b0;
    case (state_q)
      RxIdle: begin
        timer_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = RxStart;
      end
      RxStart: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (timer_q == BIT_M1) begin
          timer_d = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (brk_q) begin
          // Line held low after a bad stop bit: stay here until it idles high again.
          timer_d = '0;
          if (rx_sync_q) begin
            brk_d   = 1'b0;
            state_d = RxIdle;
          end
        end else if (timer_q == BIT_M1) begin
          timer_d = '0;
          if (rx_sync_q) begin
            byte_valid = 1'b1;
            state_d    = RxIdle;
          end else begin
            framing_err = 1'b1;
            brk_d       = 1'b1;
          end
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_data = shift_q;
  assign rx_idle   = (state_q == RxIdle);

endmodule

// File: rtl/cube_frame_rx.sv
// Cube-side frame receiver: assembles UART bytes into 64-byte frames in a double-buffered store.
module cube_frame_rx
  import cube_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = CUBE_CLKS_PER_BIT,
  parameter int unsigned IDLE_GAP_BITS = CUBE_IDLE_GAP_BITS
) (
  input logic            clk,
  input logic            rst,
  cube_frame_rx_if.slave bus
);

  localparam int unsigned IDLE_LIM = IDLE_GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned IW       = $clog2(IDLE_LIM + 1);
  localparam logic [IW-1:0]          IDLE_LIM_V = IW'(IDLE_LIM);
  localparam logic [CUBE_ADDR_W-1:0] LAST_IDX   = CUBE_ADDR_W'(FRAME_BYTES - 1);

  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   core_ferr;
  logic                   rx_idle;

  logic [CUBE_ADDR_W-1:0] idx_q, idx_d;
  logic                   sel_q, sel_d;
  logic                   valid_q, valid_d;
  logic [15:0]            count_q, count_d;
  logic [IW-1:0]          idle_q, idle_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;
  logic                   abort_q, abort_d;
  logic [CUBE_DATA_W-1:0] rd_data_q;

  // Buffer sel_q is shown to the display; writes go to the other half.
  logic [CUBE_DATA_W-1:0] frame_mem [2*FRAME_BYTES];

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_core (
    .clk        (clk),
    .rst        (rst),
    .rx         (bus.rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .framing_err(core_ferr),
    .rx_idle    (rx_idle)
  );

  always_comb begin
    idx_d   = idx_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    count_d = count_q;
    idle_d  = '0;
    done_d  = 1'b0;
    ferr_d  = core_ferr;
    abort_d = 1'b0;
    if (byte_valid) begin
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        sel_d   = ~sel_q;
        done_d  = 1'b1;
        count_d = count_q + 16'd1;
        valid_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (core_ferr) begin
      abort_d = (idx_q != '0);
      idx_d   = '0;
    end
    // Gap timer only runs between bytes of a partial frame.
    if (rx_idle && idx_q != '0) begin
      if (idle_q == IDLE_LIM_V) begin
        abort_d = 1'b1;
        idx_d   = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      count_q <= count_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      abort_q <= abort_d;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid) frame_mem[{~sel_q, idx_q}] <= byte_data;
  end

  always_ff @(posedge clk) begin
    if (rst || !valid_q) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= frame_mem[{sel_q, bus.rd_addr}];
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_done  = done_q;
  assign bus.framing_err = ferr_q;
  assign bus.frame_abort = abort_q;
  assign bus.frame_count = count_q;

endmodule

// File: tb/tb_cube_frame_rx.sv
// Directed self-checking bench for cube_frame_rx at 16 clocks per UART bit.
module tb_cube_frame_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned GAP = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cube_frame_rx_if bus ();

  cube_frame_rx #(
    .CLKS_PER_BIT (CPB),
    .IDLE_GAP_BITS(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Pulse monitor, sampled away from the active edge.
  int cyc = 0, done_cyc = 0;
  int n_done = 0, n_ferr = 0, n_abort = 0, n_both = 0, n_bad = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.frame_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc + 1;
    end
    if (bus.framing_err) n_ferr <= n_ferr + 1;
    if (bus.frame_abort) n_abort <= n_abort + 1;
    if (bus.framing_err && bus.frame_abort) n_both <= n_both + 1;
    if (bus.frame_done && (bus.framing_err || bus.frame_abort)) n_bad <= n_bad + 1;
  end

  int t_start;
  int b_done, b_ferr, b_abort, b_both;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_done  = n_done;
    b_ferr  = n_ferr;
    b_abort = n_abort;
    b_both  = n_both;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    bus.rx  = 1'b0;
    t_start = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_run(input int n, input logic [7:0] first, input logic incr);
    logic [7:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      send_byte(v, 1'b1);
      if (incr) v = v + 8'd1;
    end
  endtask

  task automatic read_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
    @(negedge clk);
    bus.rd_addr = a;
    @(negedge clk);
    check_eq(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    bit         seen;
    int         post;
    logic [5:0] a;
    bus.rx      = 1'b1;
    bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_rd_data", 32'(bus.rd_data), 32'h0);
    check_eq("rst_valid", 32'(bus.frame_valid), 32'h0);
    check_eq("rst_count", 32'(bus.frame_count), 32'h0);
    check_eq("rst_pulses", 32'({bus.frame_done, bus.framing_err, bus.frame_abort}), 32'h0);

    // Full frame 0x00..0x3F
    snap();
    send_run(64, 8'h00, 1'b1);
    check_eq("full_done_cnt", 32'(n_done - b_done), 32'd1);
    check_eq("full_done_lat", 32'(done_cyc - t_start), 32'd156);
    check_eq("full_count", 32'(bus.frame_count), 32'd1);
    check_eq("full_valid", 32'(bus.frame_valid), 32'd1);
    for (int k = 0; k < 64; k++) begin
      a = 6'(k);
      read_chk("full_rd", a, 8'(k));
    end

    // Double buffer: A all 0xAA, then B all 0x55 streamed under continuous reads
    send_run(64, 8'hAA, 1'b0);
    seen = 1'b0;
    post = 0;
    fork
      send_run(64, 8'h55, 1'b0);
      begin
        for (int c = 0; c < 64 * 180 && post < 8; c++) begin
          @(negedge clk);
          check_eq("dbuf_rd", 32'(bus.rd_data), seen ? 32'h55 : 32'hAA);
          if (bus.frame_done) seen = 1'b1;
          else if (seen) post++;
          bus.rd_addr = 6'(c);
        end
      end
    join
    check_eq("dbuf_swap_seen", 32'(seen), 32'd1);
    check_eq("dbuf_count", 32'(bus.frame_count), 32'd3);

    // Framing error on byte 10
    pulse_reset();
    snap();
    send_run(10, 8'h00, 1'b1);
    send_byte(8'h0A, 1'b0);
    bus.rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_eq("ferr_cnt", 32'(n_ferr - b_ferr), 32'd1);
    check_eq("ferr_abort_cnt", 32'(n_abort - b_abort), 32'd1);
    check_eq("ferr_coincide", 32'(n_both - b_both), 32'd1);
    check_eq("ferr_no_swap", 32'(n_done - b_done), 32'd0);
    check_eq("ferr_count0", 32'(bus.frame_count), 32'd0);
    send_run(64, 8'h40, 1'b1);
    check_eq("ferr_then_done", 32'(n_done - b_done), 32'd1);
    check_eq("ferr_then_count", 32'(bus.frame_count), 32'd1);
    read_chk("ferr_rd0", 6'd0, 8'h40);
    read_chk("ferr_rd10", 6'd10, 8'h4A);
    read_chk("ferr_rd63", 6'd63, 8'h7F);

    // Idle gap abort after 30 bytes
    pulse_reset();
    snap();
    send_run(30, 8'hE0, 1'b1);
    repeat (GAP * CPB) @(negedge clk);
    check_eq("gap_abort_cnt", 32'(n_abort - b_abort), 32'd1);
    check_eq("gap_no_ferr", 32'(n_ferr - b_ferr), 32'd0);
    check_eq("gap_no_swap", 32'(n_done - b_done), 32'd0);

    // Next frame, with a short glitch after byte 5 that must not disturb the index
    snap();
    send_run(5, 8'h80, 1'b1);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (CPB / 2 - 2) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_eq("glitch_no_pulse", 32'((n_done - b_done) + (n_ferr - b_ferr) + (n_abort - b_abort)),
             32'd0);
    send_run(59, 8'h85, 1'b1);
    check_eq("gap_then_done", 32'(n_done - b_done), 32'd1);
    check_eq("gap_then_count", 32'(bus.frame_count), 32'd1);
    read_chk("gap_rd0", 6'd0, 8'h80);
    read_chk("gap_rd5", 6'd5, 8'h85);
    read_chk("gap_rd63", 6'd63, 8'hBF);

    // Reset in the middle of a second frame
    send_run(40, 8'h33, 1'b0);
    pulse_reset();
    check_eq("mrst_valid", 32'(bus.frame_valid), 32'd0);
    check_eq("mrst_count", 32'(bus.frame_count), 32'd0);
    check_eq("mrst_pulses", 32'({bus.frame_done, bus.framing_err, bus.frame_abort}), 32'h0);
    read_chk("mrst_rd_zero", 6'd0, 8'h00);
    snap();
    send_run(64, 8'hC0, 1'b1);
    check_eq("mrst_then_done", 32'(n_done - b_done), 32'd1);
    check_eq("mrst_then_count", 32'(bus.frame_count), 32'd1);
    check_eq("mrst_then_valid", 32'(bus.frame_valid), 32'd1);
    read_chk("mrst_rd0", 6'd0, 8'hC0);
    read_chk("mrst_rd39", 6'd39, 8'hE7);
    read_chk("mrst_rd63", 6'd63, 8'hFF);

    check_eq("done_never_with_err", 32'(n_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
